ac_serial_writer: RTL and testbench

- Write-side controller for the N-bit signed accumulator register. It accepts LOAD/ADD/SUB/CLR commands over a valid/ready handshake.
- ADD/SUB are computed bit-serially, LSB first, one ripple-carry stage per cycle, against a snapshot of the accumulator's output.
- It then drives a single-cycle write strobe (ac_en/ac_in) into the accumulator.
- It is the sole writer of the accumulator in the datapath.

---
 rtl/ac_serial_writer_pkg.sv | 24 ++
 rtl/ac_serial_writer_serial_full_adder.sv | 28 ++
 rtl/ac_serial_writer.sv | 104 ++++++++++
 tb/tb_ac_serial_writer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ac_serial_writer_pkg.sv
// Shared definitions for the serial accumulator write controller.
// Op codes, FSM states and the counter width helper.
package ac_serial_writer_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_WRITE
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/ac_serial_writer_serial_full_adder.sv
// One-bit full adder with a registered carry for LSB-first arithmetic.
// cin/cout of the active stage also expose signed overflow at the MSB.
module serial_full_adder (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic cinit,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s,
  output logic cin,
  output logic cout
);

  logic c;

  always_ff @(posedge clk) begin
    if (rst)       c <= 1'b0;
    else if (load) c <= cinit;
    else if (en)   c <= cout;
  end

  assign cin  = c;
  assign s    = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/ac_serial_writer.sv
// Write-side controller for the accumulator: LOAD/ADD/SUB/CLR with
// bit-serial ADD/SUB and a single-cycle write strobe.
module ac_serial_writer
  import ac_serial_writer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [N-1:0] cmd_data,
  input  logic [N-1:0] ac_out,
  output logic         ac_en,
  output logic [N-1:0] ac_in,
  output logic         busy,
  output logic         done,
  output logic         ovf
);

  localparam int CW = clog2(N);

  state_t        state;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [CW-1:0] cnt;
  logic          is_sub;
  logic          last;
  logic          s;
  logic          cin;
  logic          cout;
  logic          accept;

  assign accept = cmd_valid & (state == ST_IDLE);
  assign is_sub = (cmd_op == OP_SUB);
  assign last   = (cnt == CW'(N - 1));

  serial_full_adder u_sfa (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .cinit(is_sub),
    .en   (state == ST_CALC),
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .s    (s),
    .cin  (cin),
    .cout (cout)
  );

  // Sum bits enter a_sh from the top as operand bits leave the bottom,
  // so after N steps a_sh holds the full result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      cnt   <= '0;
      ac_in <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            ovf  <= 1'b0;
            a_sh <= ac_out;
            b_sh <= is_sub ? ~cmd_data : cmd_data;
            cnt  <= '0;
            unique case (cmd_op)
              OP_LOAD: begin
                ac_in <= cmd_data;
                state <= ST_WRITE;
              end
              OP_CLR: begin
                ac_in <= '0;
                state <= ST_WRITE;
              end
              default: state <= ST_CALC;
            endcase
          end
        end
        ST_CALC: begin
          a_sh <= {s, a_sh[N-1:1]};
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
          if (last) begin
            ac_in <= {s, a_sh[N-1:1]};
            ovf   <= cin ^ cout;
            state <= ST_WRITE;
          end
        end
        ST_WRITE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign ac_en     = (state == ST_WRITE);
  assign done      = (state == ST_WRITE);

endmodule

// File: tb/tb_ac_serial_writer.sv
// Scoreboard bench for ac_serial_writer with an accumulator model.
// Directed commands push expected writes; a monitor checks each strobe.
module tb_ac_serial_writer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [N-1:0] cmd_data = '0;
  logic [N-1:0] ac_out;
  logic         ac_en;
  logic [N-1:0] ac_in;
  logic         busy;
  logic         done;
  logic         ovf;

  logic [N-1:0] acc = '0;
  logic [N-1:0] ovr = '0;
  logic         ovr_en = 1'b0;

  typedef struct packed {
    logic [N-1:0] v;
    logic         o;
  } exp_t;

  exp_t q[$];
  int applied = 0;
  int errs = 0;
  int writes = 0;
  int issued = 0;

  ac_serial_writer #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .ac_out   (ac_out),
    .ac_en    (ac_en),
    .ac_in    (ac_in),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  assign ac_out = ovr_en ? ovr : acc;

  always @(posedge clk)
    if (ac_en === 1'b1) acc <= ac_in;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ac_en !== 1'b0) begin
      exp_t e;
      writes++;
      chk("done_with_en", {31'd0, done}, 32'd1);
      chk("write_expected", {31'd0, q.size() > 0}, 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ac_in", {24'd0, ac_in}, {24'd0, e.v});
        chk("ovf", {31'd0, ovf}, {31'd0, e.o});
      end
    end
  end

  // Caller is at a negedge; returns at the negedge where cmd_ready is back.
  task automatic issue(input logic [1:0] op, input logic [N-1:0] d,
                       input logic [N-1:0] ev, input logic eo,
                       input bit hold, input bit snap, input int exp_low);
    int t, low, wr, bz;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", {31'd0, t < 20}, 32'd1);
    e.v = ev;
    e.o = eo;
    q.push_back(e);
    issued++;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
    if (snap) begin
      ovr    = 8'h55;
      ovr_en = 1'b1;
    end
    low = 0;
    wr  = -1;
    bz  = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && low < 20) begin
      low++;
      if (ac_en === 1'b1) wr = low;
      if (busy === 1'b1) bz++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    ovr_en    = 1'b0;
    chk("ready_low_cycles", low, exp_low);
    chk("write_cycle", wr, exp_low);
    chk("busy_cycles", bz, exp_low);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_ac_en", {31'd0, ac_en}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_ac_in", {24'd0, ac_in}, 32'd0);

    issue(2'b00, 8'd5, 8'h05, 1'b0, 0, 0, 1);
    issue(2'b01, 8'd3, 8'h08, 1'b0, 1, 0, 9);
    issue(2'b00, 8'd127, 8'h7F, 1'b0, 0, 0, 1);
    issue(2'b01, 8'd1, 8'h80, 1'b1, 0, 0, 9);
    repeat (2) @(negedge clk);
    chk("ovf_hold", {31'd0, ovf}, 32'd1);
    issue(2'b10, 8'd1, 8'h7F, 1'b1, 0, 0, 9);
    issue(2'b00, 8'd3, 8'h03, 1'b0, 0, 0, 1);
    issue(2'b10, 8'd7, 8'hFC, 1'b0, 0, 0, 9);
    issue(2'b11, 8'h5A, 8'h00, 1'b0, 0, 0, 1);
    issue(2'b00, 8'd20, 8'h14, 1'b0, 0, 0, 1);
    issue(2'b01, 8'd2, 8'h16, 1'b0, 0, 1, 9);
    issue(2'b00, 8'd127, 8'h7F, 1'b0, 0, 0, 1);
    issue(2'b01, 8'd1, 8'h80, 1'b1, 0, 0, 9);

    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_data  = 8'd1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    chk("mid_rst_ac_in", {24'd0, ac_in}, 32'd0);
    repeat (12) @(negedge clk);
    chk("mid_rst_acc", {24'd0, acc}, 32'h80);
    chk("write_count", writes, issued);
    chk("queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
    $finish;
  end

endmodule
